// File: rtl/sc_spi_arb_pkg.sv
// sc_spi_arb_pkg: shared FSM state type, field widths and round-robin helper
// for the SPI frame arbiter. Imported by the interface, picker and top.
package sc_spi_arb_pkg;

   typedef enum logic [2:0] {
      sIDLE  = 3'd0,
      sSTART = 3'd1,
      sWAIT  = 3'd2,
      sRUN   = 3'd3,
      sDONE  = 3'd4
   } state_t;

   localparam int CSSEL_W = 5;
   localparam int DW_W    = 9;
   localparam int CS_T_W  = 4;
   localparam int MODE_W  = 3;
   localparam int WORD_W  = 32;
   localparam int DPT_W   = 4;

   // Index following idx, wrapping at n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/sc_spi_arb_if.sv
// sc_spi_arb_if: requester-side and engine-side signals of the SPI frame
// arbiter. Modport master is the arbiter's view; modport slave is the view of
// everything around it (requester front-ends and the protocol engine).
interface sc_spi_arb_if
   import sc_spi_arb_pkg::*;
   #(parameter int NUM_REQ = 4);

   // requester side
   logic [NUM_REQ-1:0]         REQ;
   logic [NUM_REQ-1:0]         REQ_LAST;
   logic [CSSEL_W*NUM_REQ-1:0] REQ_CSSEL;
   logic [DW_W*NUM_REQ-1:0]    REQ_DWIDTH;
   logic [CS_T_W*NUM_REQ-1:0]  REQ_CSSETUP;
   logic [CS_T_W*NUM_REQ-1:0]  REQ_CSHOLD;
   logic [MODE_W*NUM_REQ-1:0]  REQ_MODE;
   logic [WORD_W*NUM_REQ-1:0]  REQ_TXDATA;
   logic [NUM_REQ-1:0]         GNT;
   logic [NUM_REQ-1:0]         DONE;
   logic [NUM_REQ-1:0]         REQ_RXVALID;
   logic [WORD_W-1:0]          REQ_RXDATA;
   logic [DPT_W-1:0]           REQ_RXDPT;
   logic [DPT_W-1:0]           REQ_TXDPT;

   // engine side
   logic                       SPISTART;
   logic                       SPIBUSY;
   logic [CSSEL_W-1:0]         CSSEL;
   logic [DW_W-1:0]            DWIDTH;
   logic [CS_T_W-1:0]          CSSETUP;
   logic [CS_T_W-1:0]          CSHOLD;
   logic                       CPOL;
   logic                       CPHA;
   logic                       BORDER;
   logic                       CSEXTEND;
   logic [WORD_W-1:0]          TXDATA;
   logic [DPT_W-1:0]           TXDPT;
   logic [WORD_W-1:0]          RXDATA;
   logic                       RXVALID;
   logic [DPT_W-1:0]           RXDPT;

   modport master (
      input  REQ, REQ_LAST, REQ_CSSEL, REQ_DWIDTH, REQ_CSSETUP, REQ_CSHOLD,
             REQ_MODE, REQ_TXDATA,
      output GNT, DONE, REQ_RXVALID, REQ_RXDATA, REQ_RXDPT, REQ_TXDPT,
      output SPISTART, CSSEL, DWIDTH, CSSETUP, CSHOLD, CPOL, CPHA, BORDER,
             CSEXTEND, TXDATA,
      input  SPIBUSY, TXDPT, RXDATA, RXVALID, RXDPT
   );

   modport slave (
      output REQ, REQ_LAST, REQ_CSSEL, REQ_DWIDTH, REQ_CSSETUP, REQ_CSHOLD,
             REQ_MODE, REQ_TXDATA,
      input  GNT, DONE, REQ_RXVALID, REQ_RXDATA, REQ_RXDPT, REQ_TXDPT,
      input  SPISTART, CSSEL, DWIDTH, CSSETUP, CSHOLD, CPOL, CPHA, BORDER,
             CSEXTEND, TXDATA,
      output SPIBUSY, TXDPT, RXDATA, RXVALID, RXDPT
   );

endinterface

// File: rtl/sc_spi_arb_rr_pick.sv
// sc_spi_rr_pick: combinational winner selection over a request vector.
// Default: round-robin search starting at i_ptr.
// With SC_SPI_ARB_FIXPRI_EN defined: fixed priority, lowest index wins and
// i_ptr is ignored.
module sc_spi_rr_pick
   #(parameter  int NUM_REQ = 4,
     localparam int RW      = $clog2(NUM_REQ))
   (input  logic [NUM_REQ-1:0] i_req,
    input  logic [RW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [RW-1:0]      o_idx,
    output logic               o_any);

`ifdef SC_SPI_ARB_FIXPRI_EN
   logic w_unused_ptr;
   assign w_unused_ptr = ^i_ptr;

   // Scan from the top down so the lowest requesting index is the last write.
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req[RW'(i)]) begin
            o_gnt          = '0;
            o_gnt[RW'(i)]  = 1'b1;
            o_idx          = RW'(i);
            o_any          = 1'b1;
         end
      end
   end
`else
   // Scan offsets from the far end back to i_ptr so the nearest requester
   // at or after the pointer is the last write.
   always_comb begin
      int j;
      j     = 0;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(i_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (i_req[RW'(j)]) begin
            o_gnt          = '0;
            o_gnt[RW'(j)]  = 1'b1;
            o_idx          = RW'(j);
            o_any          = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/sc_spi_arb.sv
// sc_spi_arb: frame arbiter/sequencer sharing one SPI protocol engine among
// NUM_REQ requesters. Grants round-robin (fixed priority when
// SC_SPI_ARB_FIXPRI_EN is defined), latches the winner's frame config,
// pulses SPISTART, routes TX/RX words and keeps the grant locked across
// CS-extended multi-frame transactions.
module sc_spi_arb
   import sc_spi_arb_pkg::*;
   #(parameter int NUM_REQ = 4)
   (input logic          SPICLK,
    input logic          SYSRSTB,
    sc_spi_arb_if.master bus);

   localparam int RW = $clog2(NUM_REQ);

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_gnt;
   logic [NUM_REQ-1:0]   r_done;
   logic [RW-1:0]        r_own;
   logic [RW-1:0]        r_ptr;
   logic                 r_lock;
   logic                 r_start;
   logic                 r_last;
   logic                 r_csext;
   logic [CSSEL_W-1:0]   r_cssel;
   logic [DW_W-1:0]      r_dwidth;
   logic [CS_T_W-1:0]    r_cssetup;
   logic [CS_T_W-1:0]    r_cshold;
   logic [MODE_W-1:0]    r_mode;

   logic [NUM_REQ-1:0]   w_gnt;
   logic [RW-1:0]        w_idx;
   logic                 w_any;
   logic [RW-1:0]        w_cand;
   logic                 w_take;
   logic                 w_last;
   logic [CSSEL_W-1:0]   w_cssel;
   logic [DW_W-1:0]      w_dw;
   logic [CS_T_W-1:0]    w_setup;
   logic [CS_T_W-1:0]    w_hold;
   logic [MODE_W-1:0]    w_mode;

   sc_spi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .i_req (bus.REQ),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // A locked transaction only ever considers its current owner.
   assign w_cand  = r_lock ? r_own : w_idx;
   assign w_take  = ~bus.SPIBUSY & (r_lock ? bus.REQ[r_own] : w_any);
   assign w_last  = bus.REQ_LAST[w_cand];
   assign w_cssel = bus.REQ_CSSEL[int'(w_cand)*CSSEL_W +: CSSEL_W];
   assign w_dw    = bus.REQ_DWIDTH[int'(w_cand)*DW_W +: DW_W];
   assign w_setup = bus.REQ_CSSETUP[int'(w_cand)*CS_T_W +: CS_T_W];
   assign w_hold  = bus.REQ_CSHOLD[int'(w_cand)*CS_T_W +: CS_T_W];
   assign w_mode  = bus.REQ_MODE[int'(w_cand)*MODE_W +: MODE_W];

   // Frame sequencer: grant, start pulse, engine busy tracking, done/lock.
   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      if (!SYSRSTB) begin
         r_state   <= sIDLE;
         r_gnt     <= '0;
         r_done    <= '0;
         r_own     <= '0;
         r_ptr     <= '0;
         r_lock    <= 1'b0;
         r_start   <= 1'b0;
         r_last    <= 1'b0;
         r_csext   <= 1'b0;
         r_cssel   <= '0;
         r_dwidth  <= '0;
         r_cssetup <= '0;
         r_cshold  <= '0;
         r_mode    <= '0;
      end else begin
         r_start <= 1'b0;
         r_done  <= '0;
         case (r_state)
            sIDLE: begin
               if (w_take) begin
                  // chip select is fixed for the whole locked transaction
                  if (!r_lock) begin
                     r_gnt   <= w_gnt;
                     r_own   <= w_idx;
                     r_cssel <= w_cssel;
                  end
                  r_dwidth  <= w_dw;
                  r_cssetup <= w_setup;
                  r_cshold  <= w_hold;
                  r_mode    <= w_mode;
                  r_last    <= w_last;
                  r_csext   <= ~w_last;
                  r_state   <= sSTART;
               end
            end
            sSTART: begin
               r_start <= 1'b1;
               r_state <= sWAIT;
            end
            sWAIT: begin
               if (bus.SPIBUSY) r_state <= sRUN;
            end
            sRUN: begin
               if (!bus.SPIBUSY) begin
                  r_done  <= r_gnt;
                  r_state <= sDONE;
               end
            end
            sDONE: begin
               if (r_last) begin
                  r_lock <= 1'b0;
                  r_gnt  <= '0;
                  r_ptr  <= RW'(rr_next(int'(r_own), NUM_REQ));
               end else begin
                  r_lock <= 1'b1;
               end
               r_state <= sIDLE;
            end
            default: r_state <= sIDLE;
         endcase
      end
   end

   assign bus.GNT         = r_gnt;
   assign bus.DONE        = r_done;
   assign bus.SPISTART    = r_start;
   assign bus.CSSEL       = r_cssel;
   assign bus.DWIDTH      = r_dwidth;
   assign bus.CSSETUP     = r_cssetup;
   assign bus.CSHOLD      = r_cshold;
   assign bus.BORDER      = r_mode[2];
   assign bus.CPOL        = r_mode[1];
   assign bus.CPHA        = r_mode[0];
   assign bus.CSEXTEND    = r_csext;
   assign bus.TXDATA      = (|r_gnt) ? bus.REQ_TXDATA[int'(r_own)*WORD_W +: WORD_W] : '0;
   assign bus.REQ_TXDPT   = bus.TXDPT;
   assign bus.REQ_RXDATA  = bus.RXDATA;
   assign bus.REQ_RXDPT   = bus.RXDPT;
   assign bus.REQ_RXVALID = {NUM_REQ{bus.RXVALID}} & r_gnt;

endmodule
